register_file: RTL and testbench

- 16x8 configuration/data register file directly downstream of the system controller.
- Accepts the controller's Address/WrEn/RdEn/WrData strobes and returns RdData with a one-cycle-registered RdData_Valid.
- Exposes registers 0-3 as dedicated outputs:
  - REG0/REG1 feed the ALU operands A/B.
  - REG2 holds UART configuration.
  - REG3 holds the clock-divider ratio.

---
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 16x8 configuration/data register file with a registered read port and
// dedicated continuous views of registers 0-3 (ALU operands, UART config, divider).
module register_file #(
    parameter int unsigned               DATA_WIDTH = 8,
    parameter int unsigned               ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0]     REG2_RST   = 8'h81,
    parameter logic [DATA_WIDTH-1:0]     REG3_RST   = 8'h20
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] REG0,
    output logic [DATA_WIDTH-1:0] REG1,
    output logic [DATA_WIDTH-1:0] REG2,
    output logic [DATA_WIDTH-1:0] REG3
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        READ_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            mem_q[2] <= REG2_RST;
            mem_q[3] <= REG3_RST;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

    // A simultaneous write and read is treated as a write only.
    always_comb begin
        mem_d     = mem_q;
        state_d   = IDLE;
        rd_data_d = rd_data_q;
        if (WrEn) begin
            mem_d[Address] = WrData;
        end else if (RdEn) begin
            state_d   = READ_RESP;
            rd_data_d = mem_q[Address];
        end
    end

    always_comb begin
        RdData       = rd_data_q;
        RdData_Valid = (state_q == READ_RESP);
        REG0         = mem_q[0];
        REG1         = mem_q[1];
        REG2         = mem_q[2];
        REG3         = mem_q[3];
    end

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file; expected read data is queued
// by the driver and consumed by a negedge monitor whenever RdData_Valid is seen.
module tb_register_file;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] Address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] REG0, REG1, REG2, REG3;

    register_file #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .REG2_RST   (8'h81),
        .REG3_RST   (8'h20)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .REG0         (REG0),
        .REG1         (REG1),
        .REG2         (REG2),
        .REG3         (REG3)
    );

    always #5 CLK = ~CLK;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mdl [16];
    logic [7:0] exp_q [$];
    logic [7:0] rd_last;
    logic       exp_valid;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl[2]    = 8'h81;
        mdl[3]    = 8'h20;
        rd_last   = 8'h00;
        exp_valid = 1'b0;
        exp_q.delete();
    endtask

    // Drive one access, let the clock edge take it, and update the reference model.
    task automatic do_cycle(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
        WrEn    = we;
        RdEn    = re;
        Address = a;
        WrData  = d;
        @(posedge CLK);
        exp_valid = RST && re && !we;
        if (RST) begin
            if (we) begin
                mdl[a] = d;
            end else if (re) begin
                exp_q.push_back(mdl[a]);
                rd_last = mdl[a];
            end
        end
        #1;
        WrEn = 1'b0;
        RdEn = 1'b0;
    endtask

    // Monitor: cycle-accurate valid, queued read data, held RdData and register views.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            check("rd_valid", {7'b0, RdData_Valid}, {7'b0, exp_valid});
            if (RdData_Valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 8'h01, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", RdData, e);
                end
            end
            check("rd_hold", RdData, rd_last);
            check("REG0", REG0, mdl[0]);
            check("REG1", REG1, mdl[1]);
            check("REG2", REG2, mdl[2]);
            check("REG3", REG3, mdl[3]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;

        // Reset values of all locations
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 1'b1, 4'(i), 8'h00);
            do_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        end

        // Back-to-back writes to the ALU operand registers
        do_cycle(1'b1, 1'b0, 4'h0, 8'h5A);
        do_cycle(1'b1, 1'b0, 4'h1, 8'hC3);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

        // Read-after-write on consecutive edges
        do_cycle(1'b1, 1'b0, 4'h7, 8'hF0);
        do_cycle(1'b0, 1'b1, 4'h7, 8'h00);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

        // Simultaneous write and read: write wins
        do_cycle(1'b1, 1'b1, 4'h9, 8'h77);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        do_cycle(1'b0, 1'b1, 4'h9, 8'h00);

        // RdEn held for three edges
        repeat (3) do_cycle(1'b0, 1'b1, 4'h2, 8'h00);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            do_cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                     4'($urandom), 8'($urandom));
        end
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

        // Asynchronous reset with a write and a read response in flight
        do_cycle(1'b1, 1'b0, 4'h3, 8'hAA);
        do_cycle(1'b0, 1'b1, 4'h3, 8'h00);
        RST = 1'b0;
        model_reset();
        #1;
        check("async_valid", {7'b0, RdData_Valid}, 8'h00);
        check("async_REG3", REG3, 8'h20);
        check("async_rddata", RdData, 8'h00);
        do_cycle(1'b0, 1'b1, 4'h3, 8'h00);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        RST = 1'b1;
        repeat (3) do_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        do_cycle(1'b0, 1'b1, 4'h3, 8'h00);
        do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

        @(negedge CLK);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
